// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, data access) in front of a single-port memory.
// Round-robin grants; reads complete one cycle after the grant, writes complete in the grant cycle.
module mem_port_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic         if_gnt,
  output logic         if_rd_valid,
  output logic [N-1:0] if_rd_data,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wr_data,
  output logic         d_gnt,
  output logic         d_rd_valid,
  output logic [N-1:0] d_rd_data,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wr_data,
  output logic         mem_wr_ena,
  input  logic [N-1:0] mem_rd_data,
  output logic [15:0]  stall_count
);

  // state   | meaning
  // IDLE    | may grant one requester this cycle
  // RD_WAIT | memory returning read data for rd_owner_d; no grants
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

  logic [0:0]   state;
  logic         last_grant_d;
  logic         rd_owner_d;
  logic [N-1:0] if_rd_q;
  logic [N-1:0] d_rd_q;
  logic         stall;
  logic         rd_active;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst && state == IDLE && ena) begin
      if (if_req && d_req) begin
        if (last_grant_d) if_gnt = 1'b1;
        else              d_gnt  = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_ena  = 1'b0;
    if (if_gnt) begin
      mem_addr    = if_addr;
      mem_wr_data = d_wr_data;
    end else if (d_gnt) begin
      mem_addr    = d_addr;
      mem_wr_data = d_wr_data;
      mem_wr_ena  = d_we;
    end
  end

  // Read data goes straight through in the return cycle, then the captured copy is held.
  always_comb begin
    rd_active   = !rst && (state == RD_WAIT);
    if_rd_valid = rd_active && !rd_owner_d;
    d_rd_valid  = rd_active && rd_owner_d;
    if_rd_data  = '0;
    d_rd_data   = '0;
    if (!rst) begin
      if_rd_data = if_rd_valid ? mem_rd_data : if_rd_q;
      d_rd_data  = d_rd_valid  ? mem_rd_data : d_rd_q;
    end
  end

  assign stall = (if_req && !if_gnt) || (d_req && !d_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      rd_owner_d   <= 1'b0;
      if_rd_q      <= '0;
      d_rd_q       <= '0;
      stall_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_gnt) begin
            last_grant_d <= 1'b0;
            rd_owner_d   <= 1'b0;
            state        <= RD_WAIT;
          end else if (d_gnt) begin
            last_grant_d <= 1'b1;
            if (!d_we) begin
              rd_owner_d <= 1'b1;
              state      <= RD_WAIT;
            end
          end
        end
        default: begin
          if (rd_owner_d) d_rd_q  <= mem_rd_data;
          else            if_rd_q <= mem_rd_data;
          state <= IDLE;
        end
      endcase
      if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus queues expected grant/read events,
// a monitor pops and compares them whenever the DUT presents one.
module tb_mem_port_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst, ena;
  logic         if_req, d_req, d_we;
  logic [N-1:0] if_addr, d_addr, d_wr_data;
  logic         if_gnt, if_rd_valid, d_gnt, d_rd_valid, mem_wr_ena;
  logic [N-1:0] if_rd_data, d_rd_data, mem_addr, mem_wr_data, mem_rd_data;
  logic [15:0]  stall_count;

  mem_port_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rd_valid(if_rd_valid), .if_rd_data(if_rd_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wr_data(d_wr_data),
    .d_gnt(d_gnt), .d_rd_valid(d_rd_valid), .d_rd_data(d_rd_data),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
    .mem_rd_data(mem_rd_data), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kinds: 0 fetch grant, 1 data grant, 2 fetch read return, 3 data read return
  typedef struct {
    int          c;
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic        we;
  } ev_t;
  ev_t exp_q[$];

  logic [31:0] memory [logic [31:0]];

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    if (memory.exists(a)) return memory[a];
    return {a[15:0], 16'hC0DE};
  endfunction

  always @(posedge clk) begin
    mem_rd_data <= mem_lookup(mem_addr);
    if (mem_wr_ena) memory[mem_addr] = mem_wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input int kind, input logic [31:0] a,
                           input logic [31:0] b, input logic we);
    ev_t e;
    e.c = c; e.kind = kind; e.a = a; e.b = b; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b,
                         input logic we);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind %0d a=%h at cycle %0d, required none", kind, a, cyc);
    end else begin
      total--;
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_cycle", cyc, e.c);
      check("ev_a", a, e.a);
      if (kind < 2) begin
        check("ev_wdata", b, e.b);
        check("ev_we", {31'd0, we}, {31'd0, e.we});
      end
    end
  endtask

  always @(negedge clk) begin
    if (if_gnt)      observe(0, mem_addr, mem_wr_data, mem_wr_ena);
    if (d_gnt)       observe(1, mem_addr, mem_wr_data, mem_wr_ena);
    if (if_rd_valid) observe(2, if_rd_data, 32'd0, 1'b0);
    if (d_rd_valid)  observe(3, d_rd_data, 32'd0, 1'b0);
    if (!rst) begin
      check("gnt_exclusive", {31'd0, if_gnt & d_gnt}, 32'd0);
      check("gnt_without_req", {31'd0, (if_gnt & ~if_req) | (d_gnt & ~d_req)}, 32'd0);
      if (!if_gnt && !d_gnt)
        check("bus_idle_zero", {31'd0, mem_wr_ena} | mem_addr | mem_wr_data, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int c;

  initial begin
    memory[32'h40]  = 32'h2402000A;
    memory[32'h80]  = 32'h11112222;
    memory[32'h200] = 32'h33334444;
    rst = 1'b1; ena = 1'b1; if_req = 1'b1; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'h40; d_addr = '0; d_wr_data = '0;
    #1;
    check("rst_comb_gnt", {31'd0, if_gnt}, 32'd0);
    check("rst_comb_addr", mem_addr, 32'd0);
    tick(); tick();
    check("rst_stall", {16'd0, stall_count}, 32'd0);
    rst = 1'b0; if_req = 1'b0;
    tick();
    check("rst_if_rd_data", if_rd_data, 32'd0);
    check("rst_d_rd_data", d_rd_data, 32'd0);

    // single fetch, then an immediate second fetch proves return to IDLE
    c = cyc; if_req = 1'b1; if_addr = 32'h40;
    expect_ev(c, 0, 32'h40, 32'd0, 1'b0);
    expect_ev(c + 1, 2, 32'h2402000A, 32'd0, 1'b0);
    tick(); if_req = 1'b0;
    check("fetch_stall", {16'd0, stall_count}, 32'd0);
    tick(); if_req = 1'b1; if_addr = 32'h80;
    expect_ev(c + 2, 0, 32'h80, 32'd0, 1'b0);
    expect_ev(c + 3, 2, 32'h11112222, 32'd0, 1'b0);
    tick(); if_req = 1'b0;
    tick(); tick();
    check("if_rd_hold", if_rd_data, 32'h11112222);

    // tie straight after reset: fetch, data, fetch
    rst = 1'b1; tick();
    rst = 1'b0; c = cyc;
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    expect_ev(c,     0, 32'h40, 32'd0, 1'b0);
    expect_ev(c + 1, 2, 32'h2402000A, 32'd0, 1'b0);
    expect_ev(c + 2, 1, 32'h200, 32'd0, 1'b0);
    expect_ev(c + 3, 3, 32'h33334444, 32'd0, 1'b0);
    expect_ev(c + 4, 0, 32'h40, 32'd0, 1'b0);
    expect_ev(c + 5, 2, 32'h2402000A, 32'd0, 1'b0);
    repeat (5) tick();
    if_req = 1'b0; d_req = 1'b0;
    check("tie_stall", {16'd0, stall_count}, 32'd5);
    tick(); tick();
    check("d_rd_hold", d_rd_data, 32'h33334444);

    // store, fetch right behind it, then load the stored word back
    c = cyc; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wr_data = 32'hDEADBEEF;
    expect_ev(c, 1, 32'h100, 32'hDEADBEEF, 1'b1);
    tick();
    d_req = 1'b0; d_we = 1'b0; d_wr_data = '0; if_req = 1'b1; if_addr = 32'h44;
    expect_ev(c + 1, 0, 32'h44, 32'd0, 1'b0);
    expect_ev(c + 2, 2, 32'h0044C0DE, 32'd0, 1'b0);
    tick(); if_req = 1'b0;
    tick(); d_req = 1'b1; d_addr = 32'h100;
    expect_ev(c + 3, 1, 32'h100, 32'd0, 1'b0);
    expect_ev(c + 4, 3, 32'hDEADBEEF, 32'd0, 1'b0);
    tick(); d_req = 1'b0;
    tick();
    check("store_stall", {16'd0, stall_count}, 32'd5);

    // enable gating
    c = cyc; ena = 1'b0; if_req = 1'b1; if_addr = 32'h80;
    repeat (3) tick();
    ena = 1'b1;
    expect_ev(c + 3, 0, 32'h80, 32'd0, 1'b0);
    expect_ev(c + 4, 2, 32'h11112222, 32'd0, 1'b0);
    check("ena_stall", {16'd0, stall_count}, 32'd8);
    tick(); if_req = 1'b0;
    check("ena_stall_after", {16'd0, stall_count}, 32'd8);
    tick();

    // reset during the read-return cycle abandons the read
    c = cyc; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    expect_ev(c, 1, 32'h200, 32'd0, 1'b0);
    tick(); d_req = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    check("rst_rdwait_stall", {16'd0, stall_count}, 32'd0);
    check("rst_rdwait_d_rd_data", d_rd_data, 32'd0);
    if_req = 1'b1; if_addr = 32'h40;
    expect_ev(c + 2, 0, 32'h40, 32'd0, 1'b0);
    expect_ev(c + 3, 2, 32'h2402000A, 32'd0, 1'b0);
    tick(); if_req = 1'b0;
    tick();

    // saturation
    ena = 1'b0; d_req = 1'b1;
    repeat (70000) tick();
    check("sat_stall", {16'd0, stall_count}, 32'h0000FFFF);
    repeat (3) tick();
    check("sat_hold", {16'd0, stall_count}, 32'h0000FFFF);
    d_req = 1'b0; ena = 1'b1;
    repeat (4) tick();

    check("queue_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
